// File: rtl/pad_cfg_ctrl_if.sv
// Host request/response port of the pad configuration controller.
// The host drives requests as master; the controller answers as slave.
interface pad_cfg_ctrl_if #(
   parameter int IDX_W = 6
);
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_op;
   logic [IDX_W-1:0] req_idx;
   logic [7:0]       req_data;
   logic             rsp_valid;
   logic [7:0]       rsp_data;
   logic             rsp_err;

   modport master (
      output req_valid, req_op, req_idx, req_data,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_idx, req_data,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/pad_cfg_ctrl.sv
// GPIO pad configuration controller: a shadow bank updated by host requests and
// an active bank, loaded atomically on commit, that drives the bidir pad controls.
module pad_cfg_ctrl #(
   parameter int NUM_PADS = 46,
   parameter int IDX_W    = 6
) (
   input  logic                clk,
   input  logic                rst,
   pad_cfg_ctrl_if.slave       bus,
   output logic                busy,
   output logic [NUM_PADS-1:0] bidir_CS,
   output logic [NUM_PADS-1:0] bidir_SL,
   output logic [NUM_PADS-1:0] bidir_IE,
   output logic [NUM_PADS-1:0] bidir_OE,
   output logic [NUM_PADS-1:0] bidir_PU,
   output logic [NUM_PADS-1:0] bidir_PD,
   output logic [NUM_PADS-1:0] bidir_PDRV0,
   output logic [NUM_PADS-1:0] bidir_PDRV1
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BCAST = 1'b1;

   localparam logic [1:0] OP_WRITE  = 2'b00;
   localparam logic [1:0] OP_READ   = 2'b01;
   localparam logic [1:0] OP_BCAST  = 2'b10;
   localparam logic [1:0] OP_COMMIT = 2'b11;

   localparam logic [IDX_W:0]   NUM_PADS_W = (IDX_W+1)'(NUM_PADS);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_PADS - 1);

   logic [0:0]       state;
   logic [IDX_W-1:0] cnt;
   logic [7:0]       bcast_byte;
   logic [7:0]       shadow [NUM_PADS];
   logic [7:0]       active [NUM_PADS];

   logic             rsp_valid_r;
   logic [7:0]       rsp_data_r;
   logic             rsp_err_r;

   logic             idx_ok;
   logic             pu_pd;

   assign idx_ok = ({1'b0, bus.req_idx} < NUM_PADS_W);
   // Enabling pull-up and pull-down together would fight on the pad; such bytes are refused.
   assign pu_pd  = bus.req_data[4] & bus.req_data[5];

   assign bus.req_ready = (state == ST_IDLE);
   assign busy          = (state == ST_BCAST);
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_data  = rsp_data_r;
   assign bus.rsp_err   = rsp_err_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         bcast_byte  <= '0;
         rsp_valid_r <= 1'b0;
         rsp_data_r  <= '0;
         rsp_err_r   <= 1'b0;
         for (int i = 0; i < NUM_PADS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         rsp_valid_r <= 1'b0;
         rsp_data_r  <= '0;
         rsp_err_r   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  case (bus.req_op)
                     OP_WRITE: begin
                        rsp_valid_r <= 1'b1;
                        if (!idx_ok || pu_pd) rsp_err_r <= 1'b1;
                        else                  shadow[bus.req_idx] <= bus.req_data;
                     end
                     OP_READ: begin
                        rsp_valid_r <= 1'b1;
                        if (idx_ok) rsp_data_r <= shadow[bus.req_idx];
                        else        rsp_err_r  <= 1'b1;
                     end
                     OP_BCAST: begin
                        if (pu_pd) begin
                           rsp_valid_r <= 1'b1;
                           rsp_err_r   <= 1'b1;
                        end else begin
                           bcast_byte <= bus.req_data;
                           cnt        <= '0;
                           state      <= ST_BCAST;
                        end
                     end
                     OP_COMMIT: begin
                        rsp_valid_r <= 1'b1;
                        for (int i = 0; i < NUM_PADS; i++) active[i] <= shadow[i];
                     end
                     default: ;
                  endcase
               end
            end
            ST_BCAST: begin
               // One shadow entry per cycle; the response goes out as the FSM returns to idle.
               shadow[cnt] <= bcast_byte;
               if (cnt == LAST_IDX) begin
                  state       <= ST_IDLE;
                  rsp_valid_r <= 1'b1;
                  rsp_data_r  <= bcast_byte;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      bidir_CS    = '0;
      bidir_SL    = '0;
      bidir_IE    = '0;
      bidir_OE    = '0;
      bidir_PU    = '0;
      bidir_PD    = '0;
      bidir_PDRV0 = '0;
      bidir_PDRV1 = '0;
      for (int i = 0; i < NUM_PADS; i++) begin
         bidir_CS[i]    = active[i][0];
         bidir_SL[i]    = active[i][1];
         bidir_IE[i]    = active[i][2];
         bidir_OE[i]    = active[i][3];
         bidir_PU[i]    = active[i][4];
         bidir_PD[i]    = active[i][5];
         bidir_PDRV0[i] = active[i][6];
         bidir_PDRV1[i] = active[i][7];
      end
   end

endmodule

// File: tb/tb_pad_cfg_ctrl.sv
// Bench for pad_cfg_ctrl: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pad_cfg_ctrl;

   localparam int NP    = 46;
   localparam int IDX_W = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
   logic [NP-1:0] bidir_CS, bidir_SL, bidir_IE, bidir_OE;
   logic [NP-1:0] bidir_PU, bidir_PD, bidir_PDRV0, bidir_PDRV1;

   pad_cfg_ctrl_if #(.IDX_W(IDX_W)) bus ();

   pad_cfg_ctrl #(.NUM_PADS(NP), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst(rst), .bus(bus), .busy(busy),
      .bidir_CS(bidir_CS), .bidir_SL(bidir_SL), .bidir_IE(bidir_IE), .bidir_OE(bidir_OE),
      .bidir_PU(bidir_PU), .bidir_PD(bidir_PD), .bidir_PDRV0(bidir_PDRV0), .bidir_PDRV1(bidir_PDRV1)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic mon_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a broadcast is a countdown that lands the whole byte at its end.
   logic [7:0] m_shadow [NP];
   logic [7:0] m_active [NP];
   int         m_left;
   logic [7:0] m_bbyte;
   logic       e_valid, e_err;
   logic [7:0] e_data;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NP; i++) begin
            m_shadow[i] <= 8'h00;
            m_active[i] <= 8'h00;
         end
         m_left  <= 0;
         m_bbyte <= 8'h00;
         e_valid <= 1'b0;
         e_err   <= 1'b0;
         e_data  <= 8'h00;
      end else begin
         e_valid <= 1'b0;
         e_err   <= 1'b0;
         e_data  <= 8'h00;
         if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               for (int i = 0; i < NP; i++) m_shadow[i] <= m_bbyte;
               e_valid <= 1'b1;
               e_data  <= m_bbyte;
            end
         end else if (bus.req_valid) begin
            case (bus.req_op)
               2'd0: begin
                  e_valid <= 1'b1;
                  if (int'(bus.req_idx) >= NP || (bus.req_data[4] && bus.req_data[5])) e_err <= 1'b1;
                  else m_shadow[int'(bus.req_idx)] <= bus.req_data;
               end
               2'd1: begin
                  e_valid <= 1'b1;
                  if (int'(bus.req_idx) >= NP) e_err <= 1'b1;
                  else e_data <= m_shadow[int'(bus.req_idx)];
               end
               2'd2: begin
                  if (bus.req_data[4] && bus.req_data[5]) begin
                     e_valid <= 1'b1;
                     e_err   <= 1'b1;
                  end else begin
                     m_left  <= NP;
                     m_bbyte <= bus.req_data;
                  end
               end
               default: begin
                  e_valid <= 1'b1;
                  for (int i = 0; i < NP; i++) m_active[i] <= m_shadow[i];
               end
            endcase
         end
      end
   end

   function automatic logic [NP-1:0] model_bus(input int b);
      logic [NP-1:0] r;
      for (int i = 0; i < NP; i++) r[i] = m_active[i][b];
      return r;
   endfunction

   function automatic logic [NP-1:0] dut_bus(input int b);
      case (b)
         0: return bidir_CS;
         1: return bidir_SL;
         2: return bidir_IE;
         3: return bidir_OE;
         4: return bidir_PU;
         5: return bidir_PD;
         6: return bidir_PDRV0;
         default: return bidir_PDRV1;
      endcase
   endfunction

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         chk("req_ready", bus.req_ready, m_left == 0);
         chk("busy", busy, m_left != 0);
         chk("rsp_valid", bus.rsp_valid, e_valid);
         if (e_valid) begin
            chk("rsp_data", bus.rsp_data, e_data);
            chk("rsp_err", bus.rsp_err, e_err);
         end
         for (int b = 0; b < 8; b++) chk($sformatf("bus_bit%0d", b), dut_bus(b), model_bus(b));
      end
   end

   // Present a request at a falling edge and hold it until accepted.
   task automatic send(input logic [1:0] op, input logic [IDX_W-1:0] idx, input logic [7:0] d);
      int n = 0;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_idx   = idx;
      bus.req_data  = d;
      while (!bus.req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("accept_timeout", 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic get_rsp(output logic [7:0] d, output logic e);
      int n = 0;
      while (!bus.rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("rsp_timeout", 1'b0, 1'b1);
      d = bus.rsp_data;
      e = bus.rsp_err;
   endtask

   logic [7:0] rd;
   logic       re;
   logic [NP-1:0] ones;
   int         wait_n;

   initial begin
      ones = '1;
      bus.req_valid = 1'b0;
      bus.req_op    = 2'd0;
      bus.req_idx   = '0;
      bus.req_data  = 8'h00;
      repeat (3) @(negedge clk);
      rst    = 1'b0;
      mon_en = 1'b1;

      // Out of reset
      chk("rst_ready", bus.req_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_oe", bidir_OE, '0);
      chk("rst_ie", bidir_IE, '0);
      send(2'd1, 6'd5, 8'h00);
      get_rsp(rd, re);
      chk("rd5_data", rd, 8'h00);
      chk("rd5_err", re, 1'b0);

      // Write then read back-to-back, commit later
      send(2'd0, 6'd3, 8'h0D);
      send(2'd1, 6'd3, 8'h00);
      get_rsp(rd, re);
      chk("rd3_data", rd, 8'h0D);
      chk("oe3_precommit", bidir_OE[3], 1'b0);
      send(2'd3, 6'd0, 8'h00);
      chk("cs_commit", bidir_CS, 46'h8);
      chk("ie_commit", bidir_IE, 46'h8);
      chk("oe_commit", bidir_OE, 46'h8);
      chk("sl_commit", bidir_SL, '0);

      // Rejected writes and reads
      send(2'd0, 6'd46, 8'h01);
      get_rsp(rd, re);
      chk("wr46_err", re, 1'b1);
      send(2'd0, 6'd0, 8'h30);
      get_rsp(rd, re);
      chk("wr_pupd_err", re, 1'b1);
      send(2'd1, 6'd0, 8'h00);
      get_rsp(rd, re);
      chk("rd0_data", rd, 8'h00);
      send(2'd1, 6'd50, 8'h00);
      get_rsp(rd, re);
      chk("rd50_err", re, 1'b1);
      chk("rd50_data", rd, 8'h00);
      send(2'd2, 6'd9, 8'h30);
      get_rsp(rd, re);
      chk("bc_pupd_err", re, 1'b1);
      chk("bc_pupd_ready", bus.req_ready, 1'b1);

      // Broadcast with a write held behind it
      send(2'd2, 6'd0, 8'h14);
      chk("bc_busy", busy, 1'b1);
      bus.req_valid = 1'b1;
      bus.req_op    = 2'd0;
      bus.req_idx   = 6'd10;
      bus.req_data  = 8'h15;
      wait_n = 0;
      while (!bus.req_ready && wait_n < 200) begin
         @(negedge clk);
         wait_n++;
      end
      chk("bc_wait_cycles", wait_n, 46);
      chk("bc_rsp_valid", bus.rsp_valid, 1'b1);
      chk("bc_rsp_data", bus.rsp_data, 8'h14);
      chk("bc_oe_unchanged", bidir_OE, 46'h8);
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      send(2'd3, 6'd0, 8'h00);
      chk("bc_ie_all", bidir_IE, ones);
      chk("bc_pu_all", bidir_PU, ones);
      chk("bc_cs_held", bidir_CS, 46'h400);

      // Reset in the middle of a broadcast
      send(2'd2, 6'd0, 8'h0F);
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_ie", bidir_IE, '0);
      chk("mid_rst_pu", bidir_PU, '0);
      send(2'd1, 6'd0, 8'h00);
      get_rsp(rd, re);
      chk("mid_rst_rd0", rd, 8'h00);
      send(2'd1, 6'd19, 8'h00);
      get_rsp(rd, re);
      chk("mid_rst_rd19", rd, 8'h00);

      // Write then immediate commit
      send(2'd0, 6'd7, 8'hC8);
      send(2'd3, 6'd0, 8'h00);
      chk("pdrv0_7", bidir_PDRV0, 46'h80);
      chk("pdrv1_7", bidir_PDRV1, 46'h80);
      chk("oe_7", bidir_OE, 46'h80);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pad_cfg_ctrl.md
Name: pad_cfg_ctrl

Overview:
- Core-side configuration controller for the padframe's bidirectional GPIO pads.
- A host issues single-cycle requests over a valid/ready port: per-pad write, read, broadcast, commit.
- Requests update a shadow configuration bank. A commit copies the whole shadow bank atomically into the active bank.
- The active bank drives the per-pad control buses (CS, SL, IE, OE, PU, PD, PDRV0, PDRV1) of the bidir pad array.

Parameters:
- NUM_PADS, 46, number of bidir pads controlled (1..64).
- IDX_W, 6, width of the pad index field; must satisfy 2**IDX_W >= NUM_PADS.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous reset, active-high
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_op  input  2  00 write, 01 read, 10 broadcast, 11 commit
- req_idx  input  IDX_W  target pad (write/read only)
- req_data  input  8  config byte: [0]CS [1]SL [2]IE [3]OE [4]PU [5]PD [6]PDRV0 [7]PDRV1
- rsp_valid  output  1  one-cycle response pulse; no backpressure
- rsp_data  output  8  response data
- rsp_err  output  1  qualifies rsp_valid: request rejected
- busy  output  1  broadcast in progress
- bidir_CS, bidir_SL, bidir_IE, bidir_OE, bidir_PU, bidir_PD, bidir_PDRV0, bidir_PDRV1  output  NUM_PADS each  active-bank bit for pad i on bit i

Behaviour:
- Storage: shadow[NUM_PADS] and active[NUM_PADS], 8 bits each.
- Reset (async, any time, including mid-broadcast):
  - All shadow and active entries = 8'h00, so every pad output bus is all zeros (pads inert: OE=0, IE=0).
  - FSM returns to IDLE; rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, req_ready=1 from the first cycle after reset deasserts.
- FSM states: IDLE, BCAST.
  - req_ready = (state==IDLE).
  - Accept occurs when req_valid & req_ready at a rising edge.
- Write, accepted at cycle T:
  - If req_idx >= NUM_PADS, or req_data[4] and req_data[5] are both 1 (PU and PD together): no shadow change; rsp_err=1.
  - Otherwise shadow[idx] <= req_data; rsp_err=0.
  - rsp_valid=1 in cycle T+1; rsp_data=0.
- Read, accepted at T:
  - rsp_valid in T+1 with rsp_data=shadow[idx].
  - Out-of-range idx gives rsp_data=0 and rsp_err=1.
- Commit, accepted at T:
  - All active entries <= shadow in one edge; outputs change in T+1.
  - rsp_valid in T+1; rsp_data=0; rsp_err=0.
- Broadcast, accepted at T:
  - req_idx is ignored. If PU and PD are both 1: behaves like a rejected write (rsp_err in T+1, no state change, stays IDLE).
  - Otherwise the byte is latched and the FSM enters BCAST; busy=1 during cycles T+1..T+NUM_PADS.
  - Entry k is written at the edge ending cycle T+1+k, using an internal counter 0..NUM_PADS-1.
  - Exit to IDLE after count NUM_PADS-1.
  - rsp_valid in cycle T+NUM_PADS+1 with rsp_data = the broadcast byte and rsp_err=0. req_ready is high again in that same cycle.
- Active bank and output buses never change during a broadcast; they change only at a commit or reset.
- Back-to-back requests in consecutive cycles are legal in IDLE. A read issued the cycle after a write to the same idx returns the new value.
- Request fields are sampled only on accept. Requests presented while busy are held by the host (valid/ready rule: the host must not drop valid until accepted).
- Output buses are registered. There is no combinational path from req_* to bidir_* or rsp_*.

Test Plan:
- Release reset -> all bidir_* buses = 0, req_ready=1, busy=0. Read idx 5 -> rsp_data=8'h00, rsp_err=0.
- Write idx 3 = 8'h0D, then read idx 3 -> rsp_data=8'h0D. bidir_OE[3]=0 until commit. After commit: bidir_CS[3]=1, bidir_IE[3]=1, bidir_OE[3]=1, all other pads 0.
- Write idx 46 (NUM_PADS=46) and write idx 0 = 8'h30 -> both rsp_err=1. Read idx 0 -> 8'h00.
- Broadcast 8'h14 at cycle T:
  - busy high for 46 cycles; req_ready=0 for those cycles; a held write is accepted in T+47.
  - rsp_valid in T+47 with rsp_data=8'h14.
  - After commit, bidir_IE and bidir_PU = all ones.
- Assert rst at broadcast count 20 -> next cycle busy=0, reads of idx 0 and idx 19 return 8'h00, outputs all 0.
- Write idx 7 = 8'hC8 then commit in the next cycle -> bidir_PDRV0[7]=1, bidir_PDRV1[7]=1, bidir_OE[7]=1, visible in the cycle after the commit is accepted.
